// File: rtl/dmem_wb_adapter_pkg.sv
// rtl/dmem_wb_adapter_pkg.sv - shared types and constants for the data-memory Wishbone adapter
//
// Purpose: line/word/select typedefs, adapter FSM state encoding and the
//          byte-select helper shared by the adapter top and its line buffer.
// Ports:   none (package).
package dmem_wb_adapter_pkg;

  localparam int LINE_WORDS = 8;
  localparam int LINE_BYTES = 16;

  typedef logic [127:0] lc3b_line;
  typedef logic [15:0]  lc3b_wb_sel;
  typedef logic [11:0]  lc3b_wb_adr;
  typedef logic [15:0]  lc3b_word;
  typedef logic [2:0]   lc3b_word_idx;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } adapter_state_e;

  // Word byte-enables placed into the 16 line byte lanes of word w.
  function automatic lc3b_wb_sel word_sel(input logic [1:0] be, input lc3b_word_idx w);
    word_sel = lc3b_wb_sel'(be) << {w, 1'b0};
  endfunction

  // Same word copied into every lane so the slave picks it up via wb_sel.
  function automatic lc3b_line replicate_word(input lc3b_word d);
    replicate_word = {LINE_WORDS{d}};
  endfunction

endpackage

// File: rtl/dmem_wb_adapter_line_buffer.sv
// rtl/dmem_wb_adapter_line_buffer.sv - one-entry line buffer with hit compare, word mux and byte merge
//
// Purpose: holds the most recently read line so repeated accesses to it skip the bus.
// Ports:
//   clk, reset      clock, synchronous active-high reset (clears valid)
//   lookup_tag      line address compared for a hit
//   rd_word_idx     word selected onto rd_word
//   hit             valid entry whose tag equals lookup_tag
//   rd_word         selected 16-bit word of the stored line
//   fill*           load a whole line (read completion)
//   merge*          byte-merge write; applied only if merge_tag matches a valid entry
module dmem_wb_adapter_line_buffer
  import dmem_wb_adapter_pkg::*;
#(
  parameter logic LINE_BUF_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [11:0]  lookup_tag,
  input  logic [2:0]   rd_word_idx,
  output logic         hit,
  output logic [15:0]  rd_word,
  input  logic         fill,
  input  logic [11:0]  fill_tag,
  input  logic [127:0] fill_data,
  input  logic         merge,
  input  logic [11:0]  merge_tag,
  input  logic [15:0]  merge_sel,
  input  logic [127:0] merge_data
);

  logic       valid;
  lc3b_wb_adr tag;
  lc3b_line   data;
  lc3b_line   merged;
  logic       merge_hit;

  assign hit       = valid && (tag == lookup_tag);
  assign merge_hit = valid && (tag == merge_tag);
  assign rd_word   = data[{rd_word_idx, 4'b0000} +: 16];

  always_comb begin
    merged = data;
    for (int i = 0; i < LINE_BYTES; i++) begin
      if (merge_sel[i]) begin
        merged[8*i +: 8] = merge_data[8*i +: 8];
      end
    end
  end

  // The data register is loaded even when the buffer is disabled: the
  // completion cycle reads the returned word from here.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (fill) begin
      valid <= LINE_BUF_EN;
      tag   <= fill_tag;
      data  <= fill_data;
    end else if (merge && merge_hit) begin
      data  <= merged;
    end
  end

endmodule

// File: rtl/dmem_wb_adapter.sv
// rtl/dmem_wb_adapter.sv - word data-memory requests to 128-bit line Wishbone transactions
//
// Purpose: turns MEM-stage word reads/writes into single line Wishbone cycles,
//          returns the selected word with a one-cycle mem_resp, and serves
//          repeated reads of the last line from a one-line buffer.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   mem_read, mem_write        level requests held until mem_resp (write wins if both)
//   mem_address, line_offset   line address and byte offset in line ([0] ignored)
//   mem_wdata, mem_byte_enable byte-positioned write word and its enables
//   mem_rdata, mem_resp        returned word (0 when not responding) and completion pulse
//   wb_cyc .. wb_dat_o         Wishbone master outputs, driven only in BUS
//   wb_dat_i, wb_ack           Wishbone read line and acknowledge
module dmem_wb_adapter
  import dmem_wb_adapter_pkg::*;
#(
  parameter logic LINE_BUF_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [11:0]  mem_address,
  input  logic [3:0]   line_offset,
  input  logic [15:0]  mem_wdata,
  input  logic [1:0]   mem_byte_enable,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic         wb_cyc,
  output logic         wb_stb,
  output logic         wb_we,
  output logic [11:0]  wb_adr,
  output logic [15:0]  wb_sel,
  output logic [127:0] wb_dat_o,
  input  logic [127:0] wb_dat_i,
  input  logic         wb_ack
);

  adapter_state_e state, next_state;

  lc3b_word_idx w;
  logic         offset_unused;
  assign w             = line_offset[3:1];
  assign offset_unused = line_offset[0];

  lc3b_wb_adr   req_adr;
  lc3b_wb_sel   req_sel;
  logic         req_we;
  lc3b_word     req_wdata;
  lc3b_word_idx req_w;

  logic         buf_hit;
  lc3b_word     buf_word;
  lc3b_word_idx rd_idx;
  logic         read_hit;
  logic         start_req;
  logic         bus_done;

  // Both strobes high is treated as a write, so a hit needs a pure read.
  assign read_hit  = mem_read && !mem_write && buf_hit;
  assign start_req = mem_write || (mem_read && !buf_hit);
  assign bus_done  = (state == ST_BUS) && wb_ack;

  // The completion cycle reports the word of the request that went to the
  // bus, even if the offset inputs have moved on.
  assign rd_idx = (state == ST_DONE) ? req_w : w;

  dmem_wb_adapter_line_buffer #(
    .LINE_BUF_EN (LINE_BUF_EN)
  ) u_line_buffer (
    .clk         (clk),
    .reset       (reset),
    .lookup_tag  (mem_address),
    .rd_word_idx (rd_idx),
    .hit         (buf_hit),
    .rd_word     (buf_word),
    .fill        (bus_done && !req_we),
    .fill_tag    (req_adr),
    .fill_data   (wb_dat_i),
    .merge       (bus_done && req_we),
    .merge_tag   (req_adr),
    .merge_sel   (req_sel),
    .merge_data  (replicate_word(req_wdata))
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start_req) next_state = ST_BUS;
      ST_BUS:  if (wb_ack)    next_state = ST_DONE;
      ST_DONE:                next_state = ST_IDLE;
      default:                next_state = ST_IDLE;
    endcase
  end

  // Request registers keep the bus side stable while the upstream request
  // is free to drop or change.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_adr   <= '0;
      req_sel   <= '0;
      req_we    <= 1'b0;
      req_wdata <= '0;
      req_w     <= '0;
    end else if (state == ST_IDLE && start_req) begin
      req_adr   <= mem_address;
      req_sel   <= word_sel(mem_byte_enable, w);
      req_we    <= mem_write;
      req_wdata <= mem_wdata;
      req_w     <= w;
    end
  end

  always_comb begin
    mem_resp  = 1'b0;
    mem_rdata = '0;
    wb_cyc    = 1'b0;
    wb_stb    = 1'b0;
    wb_we     = 1'b0;
    wb_sel    = '0;
    wb_adr    = req_adr;
    wb_dat_o  = replicate_word(req_wdata);
    case (state)
      ST_IDLE: begin
        if (read_hit) begin
          mem_resp  = 1'b1;
          mem_rdata = buf_word;
        end
      end
      ST_BUS: begin
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_we  = req_we;
        wb_sel = req_sel;
      end
      ST_DONE: begin
        // A request withdrawn during the bus cycle gets no response.
        if (mem_read || mem_write) begin
          mem_resp  = 1'b1;
          mem_rdata = buf_word;
        end
      end
      default: ;
    endcase
  end

endmodule
